// File: rtl/cyclic_fn_checker_pkg.sv
// Shared types and constants for the cyclic function checker.
package cyclic_fn_checker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    SAMPLE,
    DONE
  } state_t;

  // Tap mask in polynomial order: bit (e-1) set for each term x^e of x^8+x^6+x^5+x^4+1.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  localparam logic [7:0] DEFAULT_LFSR_SEED = 8'hA5;

  // One right-shift step of the Fibonacci LFSR. For a right shift, term x^e taps register bit
  // 8-e, which is the bit-reversed position of the mask bit, so the mask is mirrored here.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    logic [7:0] mask;
    for (int i = 0; i < 8; i++) begin
      mask[i] = LFSR_TAPS[7-i];
    end
    return {^(cur & mask), cur[7:1]};
  endfunction

endpackage

// File: rtl/cyc_chk_lfsr.sv
// 8-bit Fibonacci LFSR stimulus source with synchronous seed load and single-step advance.
module cyc_chk_lfsr
  import cyclic_fn_checker_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [7:0] seed_i,
  output logic       out_bit_o
);

  logic [7:0] lfsr_q;

  // Reset and load both return to the seed; load has priority over step.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= seed_i;
    end else if (load_i) begin
      lfsr_q <= seed_i;
    end else if (step_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign out_bit_o = lfsr_q[0];

endmodule

// File: rtl/cyclic_fn_checker.sv
// Sequencer/checker around a cyclic-but-combinational identity block: drives stim from an LFSR,
// waits SETTLE cycles, samples resp and tallies pass/fail results.
// Optional macro CYCLIC_FN_CHECKER_XCHK_EN: case-equality compare plus an xz_cnt output.
module cyclic_fn_checker
  import cyclic_fn_checker_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 8,
  parameter int unsigned SETTLE      = 2,
  parameter int unsigned CNT_W       = 8,
  parameter logic [7:0]  LFSR_SEED   = DEFAULT_LFSR_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             stim,
  input  logic             resp,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_vld
`ifdef CYCLIC_FN_CHECKER_XCHK_EN
  ,
  output logic [CNT_W-1:0] xz_cnt
`endif
);

  localparam int unsigned       SettleW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SettleW-1:0] SettleInit = SettleW'(SETTLE - 1);
  localparam logic [CNT_W-1:0]  LastIdx    = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0]  CntMax     = {CNT_W{1'b1}};

  state_t             state_q;
  logic [SettleW-1:0] settle_q;
  logic [CNT_W-1:0]   vec_idx_q;

  logic accept;
  logic lfsr_bit;
  logic resp_pass;
  logic resp_fail;
`ifdef CYCLIC_FN_CHECKER_XCHK_EN
  logic resp_xz;
`endif

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  cyc_chk_lfsr u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .step_i    (state_q == DRIVE),
    .seed_i    (LFSR_SEED),
    .out_bit_o (lfsr_bit)
  );

  // Classify the current response against the held stimulus.
  always_comb begin
`ifdef CYCLIC_FN_CHECKER_XCHK_EN
    // Case equality so an unresolved loop (X/Z) is a definite failure.
    resp_xz   = (resp !== 1'b0) && (resp !== 1'b1);
    resp_pass = (resp === stim);
    resp_fail = !resp_pass;
`else
    // Logical compare: an X resp leaves both flags X, so neither counter moves.
    resp_pass = (resp == stim);
    resp_fail = (resp != stim);
`endif
  end

  // Run sequencer: all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      settle_q       <= '0;
      vec_idx_q      <= '0;
      stim           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
`ifdef CYCLIC_FN_CHECKER_XCHK_EN
      xz_cnt         <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            vec_idx_q      <= '0;
            done           <= 1'b0;
            busy           <= 1'b1;
`ifdef CYCLIC_FN_CHECKER_XCHK_EN
            xz_cnt         <= '0;
`endif
            state_q        <= DRIVE;
          end
        end
        DRIVE: begin
          stim     <= lfsr_bit;
          settle_q <= SettleInit;
          state_q  <= WAIT;
        end
        WAIT: begin
          if (settle_q == '0) begin
            state_q <= SAMPLE;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        SAMPLE: begin
          if (resp_pass) begin
            if (pass_cnt != CntMax) pass_cnt <= pass_cnt + 1'b1;
          end else if (resp_fail) begin
            if (fail_cnt != CntMax) fail_cnt <= fail_cnt + 1'b1;
            if (!first_fail_vld) begin
              first_fail_idx <= vec_idx_q;
              first_fail_vld <= 1'b1;
            end
          end
`ifdef CYCLIC_FN_CHECKER_XCHK_EN
          if (resp_xz && (xz_cnt != CntMax)) xz_cnt <= xz_cnt + 1'b1;
`endif
          if (vec_idx_q == LastIdx) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end else begin
            vec_idx_q <= vec_idx_q + 1'b1;
            state_q   <= DRIVE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cyclic_fn_checker.sv
// Directed table-driven bench for cyclic_fn_checker (NUM_VECTORS=8, SETTLE=2, seed A5).
module tb_cyclic_fn_checker;

  // First 8 lfsr[0] bits from seed A5 (bit k = vector k): 1,0,1,0,0,1,0,1.
  localparam logic [7:0] EXP_STIM = 8'b1010_0101;
  localparam int         EXP_LAT  = 33;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stim;
  logic       resp;
  logic       busy;
  logic       done;
  logic [7:0] pass_cnt;
  logic [7:0] fail_cnt;
  logic [7:0] first_fail_idx;
  logic       first_fail_vld;
  int         resp_mode;  // 0 identity, 1 tie low, 2 tie high, 3 inverted
  int         checks   = 0;
  int         failures = 0;

`ifdef CYCLIC_FN_CHECKER_XCHK_EN
  logic [7:0] xz_cnt;
  logic       force_x = 1'b0;
  assign resp = force_x ? 1'bx :
                (resp_mode == 0) ? stim : (resp_mode == 1) ? 1'b0 :
                (resp_mode == 2) ? 1'b1 : ~stim;
`else
  assign resp = (resp_mode == 0) ? stim : (resp_mode == 1) ? 1'b0 :
                (resp_mode == 2) ? 1'b1 : ~stim;
`endif

  always #5 clk = ~clk;

  cyclic_fn_checker dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stim           (stim),
    .resp           (resp),
    .busy           (busy),
    .done           (done),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .first_fail_idx (first_fail_idx),
    .first_fail_vld (first_fail_vld)
`ifdef CYCLIC_FN_CHECKER_XCHK_EN
    ,
    .xz_cnt         (xz_cnt)
`endif
  );

  typedef struct {
    int mode;
    int glitch_at;  // edge count at which to pulse start mid-run; 0 = never
    int exp_pass;
    int exp_fail;
    int exp_ffv;
    int exp_ffi;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run, capture the stim of every vector, and check results and latency.
  task automatic run_vec(input vec_t v, input int n);
    int         cnt;
    int         idx;
    logic [7:0] bits;
    string      tag;
    tag       = $sformatf("row%0d", n);
    resp_mode = v.mode;
    bits      = '0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    cnt   = 1;
    check({tag, "_busy_on_start"}, int'(busy), 1);
    check({tag, "_done_cleared"}, int'(done), 0);
    while (!done && cnt < 200) begin
      if (cnt == v.glitch_at) start = 1'b1;
      tick();
      start = 1'b0;
      cnt++;
      if (cnt >= 2 && ((cnt - 2) % 4) == 0) begin
        idx = (cnt - 2) / 4;
        if (idx < 8) bits[idx] = stim;
      end
    end
    check({tag, "_latency"}, cnt, EXP_LAT);
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_busy_end"}, int'(busy), 0);
    check({tag, "_stim_seq"}, int'(bits), int'(EXP_STIM));
    check({tag, "_pass_cnt"}, int'(pass_cnt), v.exp_pass);
    check({tag, "_fail_cnt"}, int'(fail_cnt), v.exp_fail);
    check({tag, "_ff_vld"}, int'(first_fail_vld), v.exp_ffv);
    if (v.exp_ffv != 0) check({tag, "_ff_idx"}, int'(first_fail_idx), v.exp_ffi);
  endtask

  initial begin
    int cnt;
    tbl[0] = '{mode: 0, glitch_at: 0,  exp_pass: 8, exp_fail: 0, exp_ffv: 0, exp_ffi: 0};
    tbl[1] = '{mode: 1, glitch_at: 0,  exp_pass: 4, exp_fail: 4, exp_ffv: 1, exp_ffi: 0};
    tbl[2] = '{mode: 2, glitch_at: 0,  exp_pass: 4, exp_fail: 4, exp_ffv: 1, exp_ffi: 1};
    tbl[3] = '{mode: 3, glitch_at: 0,  exp_pass: 0, exp_fail: 8, exp_ffv: 1, exp_ffi: 0};
    // Start pulse during vector 3 must be ignored.
    tbl[4] = '{mode: 2, glitch_at: 15, exp_pass: 4, exp_fail: 4, exp_ffv: 1, exp_ffi: 1};

    rst       = 1'b1;
    start     = 1'b0;
    resp_mode = 0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_stim", int'(stim), 0);
    check("reset_pass", int'(pass_cnt), 0);
    check("reset_fail", int'(fail_cnt), 0);
    check("reset_ff_vld", int'(first_fail_vld), 0);
    check("reset_ff_idx", int'(first_fail_idx), 0);

    // Rows run back to back: each start lands on the cycle after the previous done.
    for (int i = 0; i < 5; i++) run_vec(tbl[i], i);

    // Reset during WAIT of vector 5, with start asserted alongside it.
    resp_mode = 1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    cnt   = 1;
    while (cnt < 22) begin
      tick();
      cnt++;
    end
    check("pre_rst_pass", int'(pass_cnt), 3);
    check("pre_rst_fail", int'(fail_cnt), 2);
    check("pre_rst_busy", int'(busy), 1);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_stim", int'(stim), 0);
    check("mid_rst_pass", int'(pass_cnt), 0);
    check("mid_rst_fail", int'(fail_cnt), 0);
    check("mid_rst_ff_vld", int'(first_fail_vld), 0);
    tick();
    check("post_rst_idle", int'(busy), 0);
    run_vec(tbl[0], 5);
    run_vec(tbl[1], 6);

`ifdef CYCLIC_FN_CHECKER_XCHK_EN
    // X response on vector 0 only; identity afterwards.
    resp_mode = 0;
    force_x   = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    cnt   = 1;
    while (!done && cnt < 200) begin
      tick();
      cnt++;
      if (cnt == 5) force_x = 1'b0;
    end
    check("xchk_latency", cnt, EXP_LAT);
    check("xchk_xz_cnt", int'(xz_cnt), 1);
    check("xchk_fail_cnt", int'(fail_cnt), 1);
    check("xchk_ff_idx", int'(first_fail_idx), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cyclic_fn_checker.md
Name: cyclic_fn_checker

Overview:
- Sequencer/checker stage that wraps a cyclic-but-combinational function block.
- Drives that block's single-bit input `stim` and consumes its output `resp`.
- The wrapped function must be identity: f(x) = x.
- Each run applies NUM_VECTORS pseudo-random stimulus bits, waits SETTLE cycles per vector, samples `resp`, and tallies pass/fail counts plus the first failing index.

Parameters:
- NUM_VECTORS, 8, vectors per run; legal range 1..2**CNT_W-1.
- SETTLE, 2, idle cycles between driving `stim` and sampling `resp`; minimum 1.
- CNT_W, 8, width of the counters and the index output.
- LFSR_SEED, 8'hA5, LFSR value loaded on reset and on each accepted start; must be non-zero.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a run; honoured only in IDLE or DONE
- stim  out  1  stimulus to the cyclic block
- resp  in  1  response from the cyclic block
- busy  out  1  high while a run is in progress
- done  out  1  high while in DONE; held until the next accepted start or rst
- pass_cnt  out  CNT_W  number of vectors where resp == stim
- fail_cnt  out  CNT_W  number of vectors where resp != stim
- first_fail_idx  out  CNT_W  index (0-based) of the first failing vector
- first_fail_vld  out  1  first_fail_idx is valid

Behaviour:
- One clock: clk. Reset is synchronous, active-high: rst.
- Reset values (all outputs): state IDLE, stim 0, busy 0, done 0, pass_cnt 0, fail_cnt 0, first_fail_idx 0, first_fail_vld 0, lfsr LFSR_SEED, vec_idx 0, settle counter 0.
- States: IDLE, DRIVE, WAIT, SAMPLE, DONE.
- IDLE/DONE, start=1:
  - Clear counters, first_fail_vld and vec_idx; load lfsr = LFSR_SEED.
  - done <= 0, busy <= 1; go to DRIVE.
- DRIVE (1 cycle):
  - stim <= lfsr[0]; lfsr advances one step.
  - Settle counter <= SETTLE-1; go to WAIT.
- WAIT:
  - Decrement the settle counter; go to SAMPLE when it reads 0.
  - WAIT therefore lasts exactly SETTLE cycles.
- SAMPLE (1 cycle):
  - Compare resp with stim.
  - Equal: pass_cnt++.
  - Different: fail_cnt++; if first_fail_vld == 0, capture first_fail_idx <= vec_idx and set first_fail_vld <= 1.
  - If vec_idx == NUM_VECTORS-1: go to DONE with busy <= 0, done <= 1. Otherwise vec_idx++ and go to DRIVE.
- Per-vector latency is SETTLE+2 cycles. Run latency from start to done = 1 + NUM_VECTORS*(SETTLE+2).
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shift right, feedback into bit 7.
- Counters saturate at 2**CNT_W-1; no wrap.
- start while busy is ignored; no restart and no state change.
- start in the same cycle as rst: rst wins; the block is in IDLE next cycle.
- rst mid-run: the run is abandoned and all outputs return to their reset values.
- stim holds its value from DRIVE through SAMPLE; it changes only in DRIVE or on rst.

Optional Feature:
- Macro: CYCLIC_FN_CHECKER_XCHK_EN.
- Defined:
  - SAMPLE compares with case equality. A resp of X or Z counts as a failure.
  - Adds output xz_cnt (CNT_W, reset 0, saturating), incremented when resp is X/Z.
  - This catches an unresolved cyclic loop, e.g. a loop that powers up X before its input is driven.
- Undefined:
  - Logical comparison only. An X resp counts as neither pass nor fail (both counters hold).
  - The xz_cnt port is absent.

Decomposition:
- Package cyclic_fn_checker_pkg:
  - state_t enum {IDLE, DRIVE, WAIT, SAMPLE, DONE}
  - LFSR_TAPS = 8'b1011_1000
  - default LFSR_SEED
- Sub-module cyc_chk_lfsr: 8-bit LFSR with load/step/seed inputs, instantiated once.

Test Plan:
- Identity loop (resp = stim via the cyclic block), NUM_VECTORS=8, SETTLE=2, start pulse -> done after 33 cycles; pass_cnt=8, fail_cnt=0, first_fail_vld=0.
- resp tied to 0 -> fail_cnt equals the number of 1s in the first 8 lfsr[0] bits from seed A5; first_fail_idx = index of the first 1 bit; pass_cnt + fail_cnt = 8.
- start asserted during vector 3 -> ignored; counts and final done timing identical to the uninterrupted run.
- rst asserted during WAIT of vector 5 -> next cycle: state IDLE, busy=0, counters 0, stim 0; a fresh start reproduces the first run's results exactly.
- Back-to-back: start on the cycle after done -> counters cleared, identical stim sequence replayed (seed reloaded).
- With CYCLIC_FN_CHECKER_XCHK_EN, resp forced to X for vector 0 only -> xz_cnt=1, fail_cnt≥1, first_fail_idx=0.
